// File: rtl/ones_pattern_generator.sv
// Purpose : for a requested ones-count k, emits every WIDTH-bit word with popcount k, ascending.
// Latency : accept at t -> first word valid at t+2+(2^k-1); one candidate examined per cycle.
// Backpr. : output words held stable while o_out_valid & !i_out_ready; o_cmd_ready only when idle.
//
// Ports:
//   i_clk, i_rst        clock (rising edge), synchronous active-high reset
//   i_cmd_valid/o_cmd_ready/i_cmd_count   command handshake, k = requested ones count
//   o_cmd_err           one-cycle pulse after a command with k > WIDTH was rejected
//   o_out_valid/i_out_ready               output word handshake
//   o_out_data          generated word (popcount == k)
//   o_out_last          final word of the burst
//   o_out_index         zero-based position of the word within the burst
module ones_pattern_generator #(
    parameter int WIDTH = 3,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [CW-1:0]    i_cmd_count,
    output logic             o_cmd_err,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_data,
    output logic             o_out_last,
    output logic [WIDTH-1:0] o_out_index
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2
    } state_t;

    localparam logic [CW-1:0]    K_MAX = CW'(WIDTH);
    localparam logic [WIDTH-1:0] ONES  = {WIDTH{1'b1}};

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_k, w_k_nxt;
    logic [WIDTH-1:0] r_cand, w_cand_nxt;
    logic [WIDTH-1:0] r_data, w_data_nxt;
    logic [WIDTH-1:0] r_index, w_index_nxt;
    logic             r_last, w_last_nxt;
    logic             r_err, w_err_nxt;

    logic [CW-1:0]    w_pop;
    logic [WIDTH-1:0] w_top;
    logic             w_match;

    // Population count of the current candidate.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pop = w_pop + CW'(r_cand[i]);
        end
    end

    assign w_match = (w_pop == r_k);
    // Largest word with k ones: k ones packed at the MSB end (zero when k = 0).
    assign w_top   = ~(ONES >> r_k);

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_cand_nxt  = r_cand;
        w_data_nxt  = r_data;
        w_index_nxt = r_index;
        w_last_nxt  = r_last;
        w_err_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_cmd_valid) begin
                    if (i_cmd_count > K_MAX) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_k_nxt     = i_cmd_count;
                        w_cand_nxt  = '0;
                        w_index_nxt = '0;
                        w_state_nxt = SCAN;
                    end
                end
            end
            SCAN: begin
                // Every legal k has a match at or below all-ones, so cand never wraps.
                if (w_match) begin
                    w_data_nxt  = r_cand;
                    w_last_nxt  = (r_cand == w_top);
                    w_state_nxt = EMIT;
                end else begin
                    w_cand_nxt = r_cand + WIDTH'(1);
                end
            end
            EMIT: begin
                if (i_out_ready) begin
                    if (r_last) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_cand_nxt  = r_cand + WIDTH'(1);
                        w_index_nxt = r_index + WIDTH'(1);
                        w_state_nxt = SCAN;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_k     <= '0;
            r_cand  <= '0;
            r_data  <= '0;
            r_index <= '0;
            r_last  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            r_cand  <= w_cand_nxt;
            r_data  <= w_data_nxt;
            r_index <= w_index_nxt;
            r_last  <= w_last_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign o_cmd_ready = (r_state == IDLE);
    assign o_out_valid = (r_state == EMIT);
    assign o_cmd_err   = r_err;
    assign o_out_data  = r_data;
    assign o_out_last  = r_last;
    assign o_out_index = r_index;

endmodule

// File: tb/tb_ones_pattern_generator.sv
// Purpose : bench for ones_pattern_generator (WIDTH=3 and WIDTH=4 instances) with a scoreboard.
// Latency : expected first-word and inter-word latencies are carried in each scoreboard entry.
// Backpr. : out_ready is driven always-high, random or always-low; stalls must hold outputs.
module tb_ones_pattern_generator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       out_ready;
    logic       cv3, cr3, err3, ov3, ol3;
    logic [1:0] cc3;
    logic [2:0] od3, oi3;
    logic       cv4, cr4, err4, ov4, ol4;
    logic [2:0] cc4;
    logic [3:0] od4, oi4;

    ones_pattern_generator #(.WIDTH(3)) u_dut3 (
        .i_clk(clk), .i_rst(rst), .i_cmd_valid(cv3), .o_cmd_ready(cr3), .i_cmd_count(cc3),
        .o_cmd_err(err3), .o_out_valid(ov3), .i_out_ready(out_ready), .o_out_data(od3),
        .o_out_last(ol3), .o_out_index(oi3)
    );

    ones_pattern_generator #(.WIDTH(4)) u_dut4 (
        .i_clk(clk), .i_rst(rst), .i_cmd_valid(cv4), .o_cmd_ready(cr4), .i_cmd_count(cc4),
        .o_cmd_err(err4), .o_out_valid(ov4), .i_out_ready(out_ready), .o_out_data(od4),
        .o_out_last(ol4), .o_out_index(oi4)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rdy_mode = 0;   // 0: always ready, 1: random, 2: never ready

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] data;
        logic [3:0] idx;
        logic       last;
        int         delay;   // cycles from accept/previous handshake to this word's valid
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int         ref_cyc[2];
    bit         ref_ok[2];
    bit         in_v[2];
    bit         err_pend[2];
    bit         chk_idle[2];
    logic [8:0] hold[2];
    int         last_end[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    // Reference: enumerate all words in ascending order, keep those with k ones.
    function automatic void build(input int d, input int k);
        exp_t lst[$];
        exp_t e;
        int   w;
        int   prev;
        w    = (d == 0) ? 3 : 4;
        prev = -1;
        for (int v = 0; v < (1 << w); v++) begin
            if ($countones(v) == k) begin
                e.data  = v[3:0];
                e.idx   = 4'(lst.size());
                e.last  = 1'b0;
                e.delay = v - prev + 1;
                prev    = v;
                lst.push_back(e);
            end
        end
        foreach (lst[i]) begin
            e      = lst[i];
            e.last = (i == lst.size() - 1);
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endfunction

    task automatic mon(input int d, input logic cv, input logic cr, input logic [2:0] cc,
                       input logic err, input logic ov, input logic [3:0] od, input logic ol,
                       input logic [3:0] oi, input int w);
        exp_t e;
        bit   empty;
        if (rst) begin
            in_v[d] = 0; err_pend[d] = 0; chk_idle[d] = 0; ref_ok[d] = 0;
            return;
        end
        chk((d == 0) ? "cmd_err_w3" : "cmd_err_w4", 32'(err), 32'(err_pend[d]));
        err_pend[d] = 0;
        if (chk_idle[d]) begin
            chk("ready_after_last", 32'(cr), 32'd1);
            chk_idle[d] = 0;
        end
        if (cv && cr) begin
            if (int'(cc) > w) err_pend[d] = 1;
            else begin
                ref_cyc[d] = cyc;
                ref_ok[d]  = 1;
            end
        end
        if (ov) begin
            chk("ready_while_busy", 32'(cr), 32'd0);
            if (!in_v[d]) begin
                empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
                if (empty) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word dut_w%0d: got data %0h, expected no word", w, od);
                end else begin
                    if (d == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    chk("word_data_idx_last", 32'({od, oi, ol}), 32'({e.data, e.idx, e.last}));
                    if (ref_ok[d]) chk("word_latency", 32'(cyc - ref_cyc[d]), 32'(e.delay));
                end
                in_v[d] = 1;
            end else begin
                chk("stall_hold", 32'({od, oi, ol}), 32'(hold[d]));
            end
            hold[d] = {od, oi, ol};
            if (out_ready) begin
                in_v[d]    = 0;
                ref_cyc[d] = cyc;
                if (ol) begin
                    chk_idle[d] = 1;
                    last_end[d] = cyc;
                end
            end
        end else if (in_v[d]) begin
            checks++;
            errors++;
            $display("FAIL valid_dropped dut_w%0d: got out_valid 0, expected 1", w);
            in_v[d] = 0;
        end
    endtask

    always @(negedge clk) begin
        mon(0, cv3, cr3, {1'b0, cc3}, err3, ov3, {1'b0, od3}, ol3, {1'b0, oi3}, 3);
        mon(1, cv4, cr4, cc4, err4, ov4, od4, ol4, oi4, 4);
    end

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 1) == 1);
                default: out_ready = 1'b0;
            endcase
        end
    end

    task automatic drive(input int d, input bit v, input int k);
        if (d == 0) begin cv3 = v; cc3 = k[1:0]; end
        else        begin cv4 = v; cc4 = k[2:0]; end
    endtask

    task automatic wait_accept(input int d);
        bit ok = 0;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if ((d == 0) ? cr3 : cr4) begin ok = 1; break; end
        end
        if (!ok) fail_now("cmd_accept");
    endtask

    task automatic wait_done(input int d);
        bit ok = 0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (d == 0 && q0.size() == 0 && cr3 && !ov3) begin ok = 1; break; end
            if (d == 1 && q1.size() == 0 && cr4 && !ov4) begin ok = 1; break; end
        end
        if (!ok) fail_now("burst_done");
    endtask

    task automatic wait_word(input logic [2:0] val);
        bit ok = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (ov3 && od3 == val) begin ok = 1; break; end
        end
        if (!ok) fail_now("wait_word");
    endtask

    task automatic send(input int d, input int k);
        int w;
        w = (d == 0) ? 3 : 4;
        build(d, k);
        @(posedge clk); #1;
        drive(d, 1, k);
        wait_accept(d);
        @(posedge clk); #1;
        drive(d, 0, 0);
        if (k > w) begin
            @(negedge clk);
            chk("reject_ready", 32'(cr4), 32'd1);
            chk("reject_no_valid", 32'(ov4), 32'd0);
        end
        wait_done(d);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int acc;
        rst = 1'b1;
        cv3 = 1'b0; cc3 = '0; cv4 = 1'b0; cc4 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready_w3", 32'(cr3), 32'd1);
        chk("rst_outs_w3", 32'({err3, ov3, od3, ol3, oi3}), 32'd0);
        chk("rst_ready_w4", 32'(cr4), 32'd1);
        chk("rst_outs_w4", 32'({err4, ov4, od4, ol4, oi4}), 32'd0);

        // Directed bursts with out_ready held high: exact latencies.
        rdy_mode = 0;
        send(0, 1);
        send(0, 0);
        send(0, 3);
        // k=2 with random stalls.
        rdy_mode = 1;
        send(0, 2);
        send(0, 2);
        // Rejected command then a legal one on the wide instance.
        send(1, 5);
        send(1, 2);

        // Command held during an active burst is only taken in the first idle cycle.
        build(0, 1);
        build(0, 2);
        @(posedge clk); #1;
        drive(0, 1, 1);
        wait_accept(0);
        @(posedge clk); #1;
        drive(0, 1, 2);
        acc = -1;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (cr3) begin acc = cyc; break; end
        end
        chk("held_cmd_accept_cycle", 32'(acc), 32'(last_end[0] + 1));
        @(posedge clk); #1;
        drive(0, 0, 0);
        wait_done(0);

        // Reset while 010 is held in EMIT.
        rdy_mode = 2;
        build(0, 1);
        @(posedge clk); #1;
        drive(0, 1, 1);
        wait_accept(0);
        @(posedge clk); #1;
        drive(0, 0, 0);
        wait_word(3'b001);
        @(posedge clk); #1 rdy_mode = 0;
        @(posedge clk); #1 rdy_mode = 2;
        wait_word(3'b010);
        @(posedge clk); #1;
        rst = 1'b1;
        q0.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midburst_rst_valid", 32'(ov3), 32'd0);
        chk("midburst_rst_outs", 32'({err3, od3, ol3, oi3}), 32'd0);
        chk("midburst_rst_ready", 32'(cr3), 32'd1);
        rdy_mode = 0;
        send(0, 3);

        // Randomised commands, random backpressure.
        rdy_mode = 1;
        repeat (10) send(0, $urandom_range(0, 3));
        repeat (10) send(1, $urandom_range(0, 7));

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
